preg_free_list_ctrl: RTL and testbench
======================================

# preg_free_list_ctrl

Physical-register allocation controller for the rename stage of the out-of-order core. It owns the free list of physical registers, hands a free physical destination to rename each cycle an instruction with a non-zero architectural destination is renamed, and reclaims physical registers released at retire. When no register is free, it stalls rename. It sits between the rename map (consumer of `alloc_preg` as `dr_p`) and the ROB retire port (producer of freed registers).

## Interface
- `NUM_PREG`, 64: physical registers; indices are 6 bits wide.
- `NUM_AREG`, 32: architectural registers; free-list depth is `NUM_PREG-NUM_AREG` = 32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `alloc_req`  in  1  rename has an instruction needing a destination (arch `dr` != 0).
- `alloc_ready`  out  1  allocation possible this cycle.
- `alloc_preg`  out  6  physical register granted; valid when `alloc_ready`.
- `free_valid`  in  1  retire releases a physical register.
- `free_preg`  in  6  register being released.
- `init_done`  out  1  free list is initialised (state RUN).
- `free_count`  out  6  entries currently in list, 0..32.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Storage: 32 x 6-bit circular buffer, 5-bit `head` (read) and `tail` (write) pointers, 6-bit count. Pointers wrap 31->0 naturally.
- Alloc fires when `alloc_req && alloc_ready`: head advances, count decrements.
- Free accepted when `free_valid` is high in RUN, `free_preg != 0`, and the list is not overflowing: entry[tail] = `free_preg`, tail advances, count increments.
- Alloc and free in the same cycle: both take effect and count is unchanged. A freed value is not allocatable until the next cycle unless the bypass is enabled.
- FSM:
  - INIT (entered on `rst`): writes `NUM_AREG+i` into entry i, one entry per cycle for i = 0..31. Count increments each cycle. After the 32nd write, go to RUN.
  - RUN: normal operation. RUN is left only by `rst`.
- `alloc_ready` = (state==RUN) && (count != 0).
- `alloc_preg` = entry[head], combinational from registered storage.
- Error cases set `err`. In every case the free is ignored and no state changes:
  - `free_valid` during INIT.
  - `free_preg == 0` (p0 backs x0 and is never freed).
  - Free while count==32 with no alloc firing the same cycle.
- `err` clears only on `rst`.
- `alloc_req` while not ready is a stall, not an error; rename holds its inputs.

## Timing
- Reset values: `alloc_ready`=0, `alloc_preg`=0, `init_done`=0, `free_count`=0, `err`=0. Head, tail and count are 0, and state is INIT.
- `rst` deasserted at cycle 0 → entries written on cycles 0..31. `init_done` and `alloc_ready` go high at cycle 32 with `alloc_preg`=32.
- Alloc latency: 0 cycles. The grant is in the same cycle as `alloc_req`; the next head value is visible the following cycle.
- Free-to-reallocate latency: 1 cycle without the bypass.
- `free_count` reflects the state after the previous edge.
- `rst` asserted mid-operation: on the next edge, return to INIT with all outputs at reset values. Any in-flight alloc or free is discarded.
- Empty (count==0): `alloc_ready`=0. Full (count==32): a free without a concurrent alloc is an error.

## Configuration
- `FREELIST_BYPASS_EN` defined:
  - When count==0 in RUN and an accepted free arrives (`free_valid`, `free_preg != 0`), `alloc_ready`=1 and `alloc_preg`=`free_preg` in the same cycle.
  - If the alloc fires, nothing is written and count stays 0. If it does not fire, the free is written normally.
- `FREELIST_BYPASS_EN` undefined: `alloc_ready` depends only on state and count. The bypass logic is absent.

## Test plan
- Reset 2 cycles then release → `init_done`=0 for 32 cycles, then 1. Two back-to-back allocs return 32 then 33; `free_count` goes 32→31→30.
- After init, 32 consecutive allocs → grants 32..63 in order. `alloc_ready`=0 and `free_count`=0 afterwards. A further `alloc_req` is held with no state change.
- In the empty state, free p5 → next cycle `alloc_ready`=1, `alloc_preg`=5.
  - With `FREELIST_BYPASS_EN`: same-cycle grant of 5, `free_count` stays 0.
- With count=10, simultaneous alloc and free of p7 → `free_count` stays 10. p7 is granted after the 10 older entries drain (wrap of tail past 31 exercised).
- Error cases → `err`=1 and sticky; `free_count` unchanged:
  - free p0 in RUN.
  - free during INIT.
  - free with count=32 and no alloc.
- Assert `rst` after 5 allocs → outputs return to reset values next cycle. Re-init again grants 32 first.

Source files
------------

// File: rtl/preg_free_list_ctrl.sv
// Physical-register free list for the rename stage.
// Hands out free physical destinations and takes back registers released at retire.
// After reset the INIT state fills the list with NUM_AREG..NUM_PREG-1, then RUN.
// Optional macro FREELIST_BYPASS_EN: when the list is empty, a register freed in a cycle
// can be granted in that same cycle.
module preg_free_list_ctrl #(
  parameter int unsigned NUM_PREG = 64,
  parameter int unsigned NUM_AREG = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     alloc_req,
  output logic                                     alloc_ready,
  output logic [$clog2(NUM_PREG)-1:0]              alloc_preg,
  input  logic                                     free_valid,
  input  logic [$clog2(NUM_PREG)-1:0]              free_preg,
  output logic                                     init_done,
  output logic [$clog2(NUM_PREG-NUM_AREG):0]       free_count,
  output logic                                     err
);

  localparam int unsigned PW    = $clog2(NUM_PREG);
  localparam int unsigned DEPTH = NUM_PREG - NUM_AREG;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           err_q, err_d;
  logic [PW-1:0]  mem_q [DEPTH];

  logic           mem_we;
  logic [PW-1:0]  mem_wdata;
  logic           is_run, full, free_ok, free_acc, free_err;
  logic           bypass_hit, alloc_fire, bypass_take, pop, push;

  // Grant path, free acceptance and error detection.
  always_comb begin
    is_run   = (state_q == StRun);
    full     = (count_q == CW'(DEPTH));
    free_ok  = free_valid && is_run && (free_preg != '0);
`ifdef FREELIST_BYPASS_EN
    bypass_hit = free_ok && (count_q == '0);
`else
    bypass_hit = 1'b0;
`endif
    alloc_ready = is_run && ((count_q != '0) || bypass_hit);
    if (!alloc_ready) begin
      alloc_preg = '0;
    end else if (bypass_hit) begin
      alloc_preg = free_preg;
    end else begin
      alloc_preg = mem_q[head_q];
    end
    alloc_fire  = alloc_req && alloc_ready;
    // A full list may still take a free when an alloc makes room in the same cycle.
    free_acc    = free_ok && !(full && !alloc_fire);
    free_err    = free_valid && (!is_run || (free_preg == '0) || (full && !alloc_fire));
    // A bypassed grant consumes the freed register directly; the list is untouched.
    bypass_take = bypass_hit && alloc_fire;
    pop         = alloc_fire && !bypass_take;
    push        = free_acc && !bypass_take;
  end

  // Next-state: INIT fills one entry per cycle, RUN does alloc/free bookkeeping.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    err_d     = err_q | free_err;
    mem_we    = 1'b0;
    mem_wdata = free_preg;
    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_wdata = PW'(NUM_AREG) + PW'(tail_q);
        tail_d    = tail_q + AW'(1);
        count_d   = count_q + CW'(1);
        if (tail_q == AW'(DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        mem_we  = push;
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
      end
      default: state_d = StInit;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage; contents are don't-care until INIT rewrites them.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[tail_q] <= mem_wdata;
    end
  end

  assign init_done  = is_run;
  assign free_count = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// Directed bench for preg_free_list_ctrl: vector tables plus loop-generated sequences.
// Expectations follow FREELIST_BYPASS_EN when the bench is built with it.
module tb_preg_free_list_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic       alloc_ready;
  logic [5:0] alloc_preg;
  logic       free_valid;
  logic [5:0] free_preg;
  logic       init_done;
  logic [5:0] free_count;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  preg_free_list_ctrl #(
    .NUM_PREG(64),
    .NUM_AREG(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_req  (alloc_req),
    .alloc_ready(alloc_ready),
    .alloc_preg (alloc_preg),
    .free_valid (free_valid),
    .free_preg  (free_preg),
    .init_done  (init_done),
    .free_count (free_count),
    .err        (err)
  );

  typedef struct {
    logic       rst;
    logic       req;
    logic       fv;
    logic [5:0] fp;
    logic       e_ready;
    logic [5:0] e_preg;
    logic       e_done;
    logic [5:0] e_cnt;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(input int r, input int req, input int fv, input int fp,
                              input int er, input int ep, input int ed, input int ec,
                              input int ee);
    vec_t v;
    v.rst     = 1'(r);
    v.req     = 1'(req);
    v.fv      = 1'(fv);
    v.fp      = 6'(fp);
    v.e_ready = 1'(er);
    v.e_preg  = 6'(ep);
    v.e_done  = 1'(ed);
    v.e_cnt   = 6'(ec);
    v.e_err   = 1'(ee);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive one cycle's inputs at the falling edge and check outputs before the rising edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst        = v.rst;
    alloc_req  = v.req;
    free_valid = v.fv;
    free_preg  = v.fp;
    #1;
    chk({tag, ".ready"}, 32'(alloc_ready), 32'(v.e_ready));
    if (v.e_ready) chk({tag, ".preg"}, 32'(alloc_preg), 32'(v.e_preg));
    chk({tag, ".done"}, 32'(init_done), 32'(v.e_done));
    chk({tag, ".count"}, 32'(free_count), 32'(v.e_cnt));
    chk({tag, ".err"}, 32'(err), 32'(v.e_err));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst        = 1'b1;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_preg  = '0;
    repeat (n) @(posedge clk);
  endtask

  // 32 INIT cycles; optionally a free is attempted at cycle free_at (must be flagged).
  task automatic do_init(input int free_at, input string tag);
    for (int i = 0; i < 32; i++) begin
      apply(mk(0, 0, int'(i == free_at), 9, 0, 0, 0, i, int'(i > free_at)),
            $sformatf("%s.init%0d", tag, i));
      if (i == 0) chk({tag, ".rst_preg"}, 32'(alloc_preg), 32'd0);
    end
  endtask

  vec_t vt[4];
  vec_t ve[5];

  initial begin
    rst        = 1'b1;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_preg  = '0;

    do_reset(2);
    do_init(99, "a");

    vt[0] = mk(0, 1, 0, 0, 1, 32, 1, 32, 0);
    vt[1] = mk(0, 1, 0, 0, 1, 33, 1, 31, 0);
    vt[2] = mk(0, 0, 0, 0, 1, 34, 1, 30, 0);
    vt[3] = mk(0, 1, 0, 0, 1, 34, 1, 30, 0);
    for (int i = 0; i < 4; i++) apply(vt[i], $sformatf("vt%0d", i));

    for (int i = 35; i < 64; i++) apply(mk(0, 1, 0, 0, 1, i, 1, 64 - i, 0), $sformatf("drain%0d", i));

    // Empty: stalls, then free p5 becomes allocatable.
    ve[0] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
    ve[1] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
`ifdef FREELIST_BYPASS_EN
    ve[2] = mk(0, 0, 1, 5, 1, 5, 1, 0, 0);
`else
    ve[2] = mk(0, 0, 1, 5, 0, 0, 1, 0, 0);
`endif
    ve[3] = mk(0, 1, 0, 0, 1, 5, 1, 1, 0);
    ve[4] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) apply(ve[i], $sformatf("ve%0d", i));

`ifdef FREELIST_BYPASS_EN
    apply(mk(0, 1, 1, 6, 1, 6, 1, 0, 0), "byp_fire");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "byp_after");
`endif

    // head=tail=1: free 30 regs (10..39), tail reaches 31.
    for (int i = 0; i < 30; i++) begin
`ifdef FREELIST_BYPASS_EN
      apply(mk(0, 0, 1, 10 + i, 1, 10, 1, i, 0), $sformatf("fill%0d", i));
`else
      apply(mk(0, 0, 1, 10 + i, int'(i != 0), 10, 1, i, 0), $sformatf("fill%0d", i));
`endif
    end
    for (int j = 0; j < 20; j++) apply(mk(0, 1, 0, 0, 1, 10 + j, 1, 30 - j, 0), $sformatf("take%0d", j));
    // count=10: alloc + free p7 together, tail wraps 31->0.
    apply(mk(0, 1, 1, 7, 1, 30, 1, 10, 0), "simul");
    for (int k = 0; k < 9; k++) apply(mk(0, 1, 0, 0, 1, 31 + k, 1, 10 - k, 0), $sformatf("old%0d", k));
    apply(mk(0, 1, 0, 0, 1, 7, 1, 1, 0), "p7_grant");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "empty2");

    // Free of p0 is an error, sticky.
    apply(mk(0, 0, 1, 0, 0, 0, 1, 0, 0), "p0_free");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 1), "p0_err");
    apply(mk(0, 1, 0, 0, 0, 0, 1, 0, 1), "p0_sticky");

    // Free during INIT is an error.
    do_reset(1);
    do_init(3, "b");
    apply(mk(0, 0, 0, 0, 1, 32, 1, 32, 1), "init_err_sticky");

    // Overflow free at count=32, then rst after 5 allocs.
    do_reset(1);
    do_init(99, "c");
    apply(mk(0, 0, 1, 40, 1, 32, 1, 32, 0), "ovf_free");
    for (int a = 0; a < 5; a++) apply(mk(0, 1, 0, 0, 1, 32 + a, 1, 32 - a, 1), $sformatf("ovf_alloc%0d", a));
    do_reset(1);
    do_init(99, "d");
    apply(mk(0, 1, 0, 0, 1, 32, 1, 32, 0), "reinit_first");
    apply(mk(0, 0, 0, 0, 1, 33, 1, 31, 0), "reinit_second");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
